wb_arbiter: RTL



---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_arbiter_if.sv | 32 +++
 rtl/wb_fifo.sv | 72 +++++++
 rtl/wb_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;

    localparam int REG_W = 64;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] ZR_REG = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] wa;
        logic [REG_W-1:0]  wd;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus between the result producers/decode and the writeback arbiter.
interface wb_arbiter_if #(
    parameter int DEPTH = 4
);
    import wb_pkg::*;

    logic                     alu_valid;
    logic                     alu_ready;
    logic [ADDR_W-1:0]        alu_wa;
    logic [REG_W-1:0]         alu_wd;
    logic                     ld_valid;
    logic                     ld_ready;
    logic [ADDR_W-1:0]        ld_wa;
    logic [REG_W-1:0]         ld_wd;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [REG_W-1:0]         wd;
    logic [ADDR_W-1:0]        pend_ra;
    logic                     pend_hit;
    logic [$clog2(DEPTH):0]   ld_count;

    modport slave (
        input  alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd, pend_ra,
        output alu_ready, ld_ready, we, wa, wd, pend_hit, ld_count
    );

    modport master (
        output alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd, pend_ra,
        input  alu_ready, ld_ready, we, wa, wd, pend_hit, ld_count
    );

endinterface

// File: rtl/wb_fifo.sv
// Strict-order load-return FIFO; exposes per-entry valid/address for hazard lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  wb_req_t                      push_data_i,
    input  logic                         pop_i,
    output wb_req_t                      head_o,
    output logic [CNT_W-1:0]             count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [DEPTH-1:0]             ent_vld_o,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_wa_o
);

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; stale contents are masked by ent_vld_o so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        ent_vld_o = '0;
        ent_wa_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld_o[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q;
            ent_wa_o[i]  = mem_q[i].wa;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take priority, buffered loads drain when the ALU
// is idle or after the ALU has been favoured STARVE_LIMIT times in a row.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ST_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(STARVE_LIMIT);

    logic                     alu_acc, alu_wr, ld_acc, push, pop;
    logic                     fifo_full, fifo_empty, fifo_hit;
    wb_req_t                  head, push_data;
    logic [CNT_W-1:0]         count;
    logic [DEPTH-1:0]         ent_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_wa;
    logic [ST_W-1:0]          starve_q, starve_d;
    logic                     we_q, we_d;
    logic [ADDR_W-1:0]        wa_q, wa_d;
    logic [REG_W-1:0]         wd_q, wd_d;

    assign bus.ld_ready  = !fifo_full;
    assign bus.alu_ready = !(!fifo_empty && (starve_q == ST_MAX));

    // Writes to the zero register complete the handshake but are dropped here.
    assign alu_acc   = bus.alu_valid && bus.alu_ready;
    assign alu_wr    = alu_acc && (bus.alu_wa != ZR_REG);
    assign ld_acc    = bus.ld_valid && bus.ld_ready;
    assign push      = ld_acc && (bus.ld_wa != ZR_REG);
    assign pop       = !alu_wr && !fifo_empty;
    assign push_data = '{wa: bus.ld_wa, wd: bus.ld_wd};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .ent_vld_o  (ent_vld),
        .ent_wa_o   (ent_wa)
    );

    // Count consecutive skips of a non-empty FIFO; any pop or an empty FIFO clears it.
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q != ST_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Output selection: ALU first, then FIFO head; address/data hold when idle.
    always_comb begin
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (alu_wr) begin
            we_d = 1'b1;
            wa_d = bus.alu_wa;
            wd_d = bus.alu_wd;
        end else if (!fifo_empty) begin
            we_d = 1'b1;
            wa_d = head.wa;
            wd_d = head.wd;
        end
    end

    // Registered regfile write port and starve counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            starve_q <= '0;
        end else begin
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            starve_q <= starve_d;
        end
    end

    // Hazard lookup against queued loads and the write currently in the output register.
    always_comb begin
        fifo_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_wa[i] == bus.pend_ra)) begin
                fifo_hit = 1'b1;
            end
        end
    end

    assign bus.pend_hit = (bus.pend_ra != ZR_REG) &&
                          (fifo_hit || (we_q && (wa_q == bus.pend_ra)));
    assign bus.we       = we_q;
    assign bus.wa       = wa_q;
    assign bus.wd       = wd_q;
    assign bus.ld_count = count;

endmodule
